// File: rtl/bc_ram_pkg.sv
// Shared types and helpers for the parametrised BC/RT dual-port buffer.
// Holds the init FSM state type, read-during-write mode codes and ADDR_W helper.
package bc_ram_pkg;

    typedef enum logic {
        INIT_IDLE,
        INIT_CLEAR
    } init_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Address width that never collapses to zero for DEPTH <= 1.
    function automatic int clog2_min1(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/bc_ram_rd_pipe.sv
// Read-result pipeline for one RAM port: 1 or 2 register stages.
// Ports: clk, resetn, rd_en/rd_data (read issued this cycle), dout/dvalid (result).
module bc_ram_rd_pipe #(
    parameter int DATA_W   = 40,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid
);

    logic [DATA_W-1:0] s1_data;
    logic              s1_vld;

    // Data only loads on a read, so dout holds between reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= rd_en;
            if (rd_en) s1_data <= rd_data;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_vld;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    s2_data <= '0;
                    s2_vld  <= 1'b0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) s2_data <= s1_data;
                end
            end

            assign dout   = s2_data;
            assign dvalid = s2_vld;
        end else begin : g_lat1
            assign dout   = s1_data;
            assign dvalid = s1_vld;
        end
    endgenerate

endmodule

// File: rtl/bc_param_dpsram.sv
// Single-clock true dual-port SRAM with byte lanes, collision flag and clear engine.
// Ports: clk/resetn, init_req/init_busy, port A (engine), port B (host, gated by b_blk_en), collision.
module bc_param_dpsram
    import bc_ram_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int BYTE_W         = 10,
    parameter int NUM_BYTES      = 4,
    parameter int READ_LAT       = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDR_W        = clog2_min1(DEPTH),
    localparam int DATA_W        = BYTE_W * NUM_BYTES
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 init_req,
    output logic                 init_busy,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_din,
    input  logic                 a_wen,
    input  logic [NUM_BYTES-1:0] a_wbyte_en,
    input  logic                 a_ren,
    output logic [DATA_W-1:0]    a_dout,
    output logic                 a_dvalid,
    input  logic                 b_blk_en,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_din,
    input  logic                 b_wen,
    input  logic [NUM_BYTES-1:0] b_wbyte_en,
    input  logic                 b_ren,
    output logic [DATA_W-1:0]    b_dout,
    output logic                 b_dvalid,
    output logic                 collision
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    init_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              boot_q;
    logic              busy;

    logic [DATA_W-1:0] mem [DEPTH];

    logic                 a_in, b_in;
    logic [NUM_BYTES-1:0] a_wl, b_wl;
    logic                 a_rd, b_rd;
    logic [DATA_W-1:0]    a_rdata, b_rdata;
    logic                 col_q;

    assign busy      = (state_q == INIT_CLEAR);
    assign init_busy = busy;

    // boot_q requests one sweep after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= INIT_IDLE;
            cnt_q   <= '0;
            boot_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == INIT_IDLE && state_d == INIT_CLEAR) boot_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT_IDLE: begin
                if (init_req || boot_q) begin
                    state_d = INIT_CLEAR;
                    cnt_d   = '0;
                end
            end
            INIT_CLEAR: begin
                if (cnt_q == LAST) state_d = INIT_IDLE;
                else               cnt_d   = cnt_q + ADDR_W'(1);
            end
        endcase
    end

    assign a_in = (32'(a_addr) < DEPTH);
    assign b_in = (32'(b_addr) < DEPTH);

    assign a_wl = {NUM_BYTES{a_wen & ~busy & a_in}} & a_wbyte_en;
    assign b_wl = {NUM_BYTES{b_blk_en & b_wen & ~busy & b_in}} & b_wbyte_en;
    assign a_rd = a_ren & ~busy;
    assign b_rd = b_blk_en & b_ren & ~busy;

    // Old word from the array; write-first mode overlays this port's own lanes.
    always_comb begin
        a_rdata = a_in ? mem[a_addr] : '0;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (a_wl[i]) a_rdata[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
        end
    end

    always_comb begin
        b_rdata = b_in ? mem[b_addr] : '0;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (b_wl[i]) b_rdata[i*BYTE_W +: BYTE_W] = b_din[i*BYTE_W +: BYTE_W];
        end
    end

    // Port A lanes are applied last so A wins on a shared lane.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (b_wl[i]) mem[b_addr][i*BYTE_W +: BYTE_W] <= b_din[i*BYTE_W +: BYTE_W];
            for (int i = 0; i < NUM_BYTES; i++)
                if (a_wl[i]) mem[a_addr][i*BYTE_W +: BYTE_W] <= a_din[i*BYTE_W +: BYTE_W];
        end
    end

    // Flag on the write strobes, not the lanes: disjoint lane sets still collide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) col_q <= 1'b0;
        else col_q <= ~busy & a_wen & b_blk_en & b_wen & a_in & b_in & (a_addr == b_addr);
    end

    assign collision = col_q;

    bc_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_pipe_a (
        .clk     (clk),
        .resetn  (resetn),
        .rd_en   (a_rd),
        .rd_data (a_rdata),
        .dout    (a_dout),
        .dvalid  (a_dvalid)
    );

    bc_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_pipe_b (
        .clk     (clk),
        .resetn  (resetn),
        .rd_en   (b_rd),
        .rd_data (b_rdata),
        .dout    (b_dout),
        .dvalid  (b_dvalid)
    );

endmodule

// File: tb/tb_bc_param_dpsram.sv
// Bench for bc_param_dpsram: two configurations driven in lockstep
// (1024/lat1/read-first and 1000/lat2/write-first) against a reference model.
module tb_bc_param_dpsram;

    localparam int DW = 40;
    localparam int NB = 4;
    localparam int BW = 10;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          init_req;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic          a_wen, a_ren, b_blk_en, b_wen, b_ren;
    logic [NB-1:0] a_wbe, b_wbe;

    logic          init_busy [2];
    logic [DW-1:0] a_dout [2];
    logic [DW-1:0] b_dout [2];
    logic          a_dvalid [2];
    logic          b_dvalid [2];
    logic          collision [2];

    int dep [2];
    int lat [2];
    int rdw [2];

    logic [DW-1:0] mem [2][1024];
    int            clr [2];
    bit            boot [2];
    bit            hva [2][4];
    bit            hvb [2][4];
    logic [DW-1:0] hda [2][4];
    logic [DW-1:0] hdb [2][4];
    logic [DW-1:0] lasta [2];
    logic [DW-1:0] lastb [2];
    logic          ex_busy [2];
    logic          ex_av [2];
    logic          ex_bv [2];
    logic          ex_col [2];
    logic [DW-1:0] ex_ad [2];
    logic [DW-1:0] ex_bd [2];

    int n;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bc_param_dpsram #(
        .DEPTH(1024), .BYTE_W(10), .NUM_BYTES(4),
        .READ_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u_dut0 (
        .clk(clk), .resetn(resetn), .init_req(init_req), .init_busy(init_busy[0]),
        .a_addr(a_addr), .a_din(a_din), .a_wen(a_wen), .a_wbyte_en(a_wbe),
        .a_ren(a_ren), .a_dout(a_dout[0]), .a_dvalid(a_dvalid[0]),
        .b_blk_en(b_blk_en), .b_addr(b_addr), .b_din(b_din), .b_wen(b_wen),
        .b_wbyte_en(b_wbe), .b_ren(b_ren), .b_dout(b_dout[0]), .b_dvalid(b_dvalid[0]),
        .collision(collision[0])
    );

    bc_param_dpsram #(
        .DEPTH(1000), .BYTE_W(10), .NUM_BYTES(4),
        .READ_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .clk(clk), .resetn(resetn), .init_req(init_req), .init_busy(init_busy[1]),
        .a_addr(a_addr), .a_din(a_din), .a_wen(a_wen), .a_wbyte_en(a_wbe),
        .a_ren(a_ren), .a_dout(a_dout[1]), .a_dvalid(a_dvalid[1]),
        .b_blk_en(b_blk_en), .b_addr(b_addr), .b_din(b_din), .b_wen(b_wen),
        .b_wbyte_en(b_wbe), .b_ren(b_ren), .b_dout(b_dout[1]), .b_dvalid(b_dvalid[1]),
        .collision(collision[1])
    );

    task automatic chk(input string tag, input int k,
                       input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            clr[k]     = 0;
            boot[k]    = 1'b1;
            lasta[k]   = '0;
            lastb[k]   = '0;
            ex_busy[k] = 1'b0;
            ex_av[k]   = 1'b0;
            ex_bv[k]   = 1'b0;
            ex_col[k]  = 1'b0;
            ex_ad[k]   = '0;
            ex_bd[k]   = '0;
            for (int j = 0; j < 4; j++) begin
                hva[k][j] = 1'b0;
                hvb[k][j] = 1'b0;
                hda[k][j] = '0;
                hdb[k][j] = '0;
            end
        end
    endtask

    // Effect of the coming clock edge, from the inputs currently driven.
    task automatic model_edge();
        bit            busy, ain, bin;
        logic [NB-1:0] al, bl;
        logic [DW-1:0] ra, rb;
        int            idx;
        n++;
        if (!resetn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            busy = (clr[k] > 0);
            ain  = (int'(a_addr) < dep[k]);
            bin  = (int'(b_addr) < dep[k]);
            al   = (a_wen && !busy && ain) ? a_wbe : '0;
            bl   = (b_blk_en && b_wen && !busy && bin) ? b_wbe : '0;
            ra   = ain ? mem[k][a_addr] : '0;
            rb   = bin ? mem[k][b_addr] : '0;
            if (rdw[k] == 1) begin
                for (int i = 0; i < NB; i++) begin
                    if (al[i]) ra[i*BW +: BW] = a_din[i*BW +: BW];
                    if (bl[i]) rb[i*BW +: BW] = b_din[i*BW +: BW];
                end
            end
            hva[k][n%4] = a_ren && !busy;
            hda[k][n%4] = ra;
            hvb[k][n%4] = b_blk_en && b_ren && !busy;
            hdb[k][n%4] = rb;
            ex_col[k] = !busy && a_wen && b_blk_en && b_wen && ain && bin && (a_addr == b_addr);
            for (int i = 0; i < NB; i++)
                if (bl[i]) mem[k][b_addr][i*BW +: BW] = b_din[i*BW +: BW];
            for (int i = 0; i < NB; i++)
                if (al[i]) mem[k][a_addr][i*BW +: BW] = a_din[i*BW +: BW];
            if (busy) begin
                mem[k][dep[k] - clr[k]] = '0;
                clr[k]--;
            end else if (boot[k] || init_req) begin
                boot[k] = 1'b0;
                clr[k]  = dep[k];
            end
            ex_busy[k] = (clr[k] > 0);
            idx = (n - lat[k] + 1) % 4;
            ex_av[k] = hva[k][idx];
            if (hva[k][idx]) lasta[k] = hda[k][idx];
            ex_ad[k] = lasta[k];
            ex_bv[k] = hvb[k][idx];
            if (hvb[k][idx]) lastb[k] = hdb[k][idx];
            ex_bd[k] = lastb[k];
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("init_busy", k, DW'(init_busy[k]), DW'(ex_busy[k]));
            chk("a_dvalid",  k, DW'(a_dvalid[k]),  DW'(ex_av[k]));
            chk("a_dout",    k, a_dout[k],         ex_ad[k]);
            chk("b_dvalid",  k, DW'(b_dvalid[k]),  DW'(ex_bv[k]));
            chk("b_dout",    k, b_dout[k],         ex_bd[k]);
            chk("collision", k, DW'(collision[k]), DW'(ex_col[k]));
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drv_idle();
        init_req = 1'b0;
        a_wen = 1'b0; a_ren = 1'b0; a_wbe = '0;
        b_blk_en = 1'b1; b_wen = 1'b0; b_ren = 1'b0; b_wbe = '0;
    endtask

    // Runs one full sweep (bounded); optionally pokes init_req mid-sweep.
    task automatic wait_sweep(input bit poke);
        int hi [2];
        hi[0] = 0;
        hi[1] = 0;
        for (int i = 0; i < 1100; i++) begin
            init_req = poke && (i == 20);
            cycle();
            for (int k = 0; k < 2; k++)
                if (init_busy[k]) hi[k]++;
            if (i > 2 && !init_busy[0] && !init_busy[1]) break;
        end
        init_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("busy_len", k, DW'(hi[k]), DW'(dep[k]));
            chk("sweep_done", k, DW'(init_busy[k]), '0);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 9) < 7) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(990, 1023));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        dep[0] = 1024; lat[0] = 1; rdw[0] = 0;
        dep[1] = 1000; lat[1] = 2; rdw[1] = 1;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 1024; j++) mem[k][j] = '0;
        n = 8;
        drv_idle();
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
        model_reset();

        repeat (3) cycle();
        resetn = 1'b1;
        wait_sweep(1'b1);

        a_addr = 10'h3FF; a_ren = 1'b1;
        cycle();
        drv_idle();
        cycle();
        cycle();

        a_addr = 10'h010; a_din = 40'h12345_6789A; a_wbe = 4'b1111; a_wen = 1'b1;
        cycle();
        drv_idle();
        b_addr = 10'h010; b_ren = 1'b1;
        cycle();
        drv_idle();
        repeat (3) cycle();

        a_addr = 10'h020; a_din = 40'hAAAAAAAAAA; a_wbe = 4'b0011; a_wen = 1'b1;
        b_addr = 10'h020; b_din = 40'h5555555555; b_wbe = 4'b0110; b_wen = 1'b1;
        cycle();
        drv_idle();
        a_ren = 1'b1;
        cycle();
        drv_idle();
        repeat (3) cycle();

        a_addr = 10'h030; a_din = 40'h0000000001; a_wbe = 4'b1111; a_wen = 1'b1;
        cycle();
        a_din = 40'hFFFFFFFFFF; a_ren = 1'b1;
        cycle();
        drv_idle();
        repeat (3) cycle();

        b_blk_en = 1'b0; b_addr = 10'h010; b_din = 40'h0F0F0F0F0F;
        b_wbe = 4'b1111; b_wen = 1'b1; b_ren = 1'b1;
        cycle();
        drv_idle();
        a_addr = 10'h010; a_ren = 1'b1;
        cycle();
        a_addr = AW'(1005);
        cycle();
        drv_idle();
        repeat (3) cycle();

        repeat (400) begin
            a_wen    = 1'($urandom_range(0, 1));
            a_ren    = 1'($urandom_range(0, 1));
            b_blk_en = ($urandom_range(0, 3) != 0);
            b_wen    = 1'($urandom_range(0, 1));
            b_ren    = 1'($urandom_range(0, 1));
            a_wbe    = NB'($urandom_range(0, 15));
            b_wbe    = NB'($urandom_range(0, 15));
            a_din    = DW'({$urandom(), $urandom()});
            b_din    = DW'({$urandom(), $urandom()});
            a_addr   = rnd_addr();
            b_addr   = ($urandom_range(0, 2) == 0) ? a_addr : rnd_addr();
            cycle();
        end
        drv_idle();
        repeat (3) cycle();

        init_req = 1'b1;
        cycle();
        init_req = 1'b0;
        repeat (100) cycle();
        resetn = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) cycle();
        resetn = 1'b1;
        wait_sweep(1'b0);

        a_addr = 10'h010; a_ren = 1'b1;
        b_addr = 10'h020; b_ren = 1'b1;
        cycle();
        drv_idle();
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
